// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg -- shared definitions for the UART transmit arbiter slice.
//
// Contents:
//   tx_arb_state_e  : arbiter FSM state encoding (IDLE, SEND, START, WAIT_DONE)
//   DEF_NUM_REQ     : default number of transmit requesters
//   DEF_DATA_WIDTH  : default UART character width
//   DEF_MAX_BURST   : default byte limit per grant (burst-limit build only)
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } tx_arb_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 16;

endpackage

// File: rtl/uart_tx_arb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter -- combinational round-robin pick.
//
// Searches req_i starting at last_owner_i+1 and wrapping around; the first
// set bit wins. last_owner_i itself is the lowest-priority candidate.
//
// Ports:
//   req_i        in  NumReq          request vector
//   last_owner_i in  $clog2(NumReq)  index of the previous owner
//   grant_o      out NumReq          one-hot winner, zero if no request
// ---------------------------------------------------------------------------
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NumReq = DEF_NUM_REQ
) (
  input  logic [NumReq-1:0]         req_i,
  input  logic [$clog2(NumReq)-1:0] last_owner_i,
  output logic [NumReq-1:0]         grant_o
);

  always_comb begin : p_search
    int  idx;
    logic found;
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 1; off <= NumReq; off++) begin
      idx = int'(last_owner_i) + off;
      if (idx >= NumReq) begin
        idx = idx - NumReq;
      end
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb -- shares one UART transmitter between NumReq byte streams.
//
// An owner is chosen round-robin while idle and keeps the transmitter until
// it sends a byte flagged last, or presents no byte when asked (valid gap).
// Each accepted byte is handed to the transmitter with a one-cycle tx_dv_o
// pulse; the arbiter then waits for tx_busy_i to rise and fall again.
//
// Optional feature (macro UART_TX_ARB_BURST_LIMIT_EN): a per-grant byte
// counter forces a release after MaxBurst bytes, as if the byte were last.
//
// Ports:
//   clk_i        in  1                 system clock
//   rst_i        in  1                 asynchronous active-high reset
//   req_valid_i  in  NumReq            per-requester byte valid
//   req_data_i   in  NumReq*DataWidth  requester k at [k*DataWidth +: DataWidth]
//   req_last_i   in  NumReq            byte closes the requester's message
//   req_ready_o  out NumReq            byte accepted this cycle (owner only)
//   tx_dv_o      out 1                 one-cycle start pulse to transmitter
//   tx_data_o    out DataWidth         byte to transmitter, held until next accept
//   tx_busy_i    in  1                 transmitter busy
//   grant_o      out NumReq            one-hot current owner, zero when idle
// ---------------------------------------------------------------------------
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NumReq    = DEF_NUM_REQ,
  parameter int DataWidth = DEF_DATA_WIDTH,
  parameter int MaxBurst  = DEF_MAX_BURST
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_valid_i,
  input  logic [NumReq*DataWidth-1:0]   req_data_i,
  input  logic [NumReq-1:0]             req_last_i,
  output logic [NumReq-1:0]             req_ready_o,
  output logic                          tx_dv_o,
  output logic [DataWidth-1:0]          tx_data_o,
  input  logic                          tx_busy_i,
  output logic [NumReq-1:0]             grant_o
);

  localparam int IdxW = $clog2(NumReq);

  tx_arb_state_e state_reg, state_next;

  logic [NumReq-1:0]    grant_reg;
  logic [IdxW-1:0]      owner_reg;
  logic [IdxW-1:0]      last_owner_reg;
  logic [DataWidth-1:0] data_reg;
  logic                 last_cap_reg;
  logic                 dv_reg;
  // Holds off arbitration for the first edge after reset release so the
  // earliest grant lands on the second edge.
  logic                 armed_reg;

  logic [NumReq-1:0]    arb_grant;
  logic [IdxW-1:0]      arb_idx;
  logic [DataWidth-1:0] req_data_arr [NumReq];

  logic owner_valid;
  logic grant_take;
  logic accept;
  logic release_now;
  logic burst_hit;

  // Unpack the flat data bus into one lane per requester.
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_lane
    assign req_data_arr[gi] = req_data_i[gi*DataWidth +: DataWidth];
  end

  rr_arbiter #(
    .NumReq (NumReq)
  ) u_rr_arbiter (
    .req_i        (req_valid_i),
    .last_owner_i (last_owner_reg),
    .grant_o      (arb_grant)
  );

  always_comb begin : p_grant_idx
    arb_idx = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (arb_grant[k]) begin
        arb_idx = IdxW'(k);
      end
    end
  end

  assign owner_valid = req_valid_i[owner_reg];
  assign grant_take  = (state_reg == IDLE) && armed_reg && (|req_valid_i);
  assign accept      = (state_reg == SEND) && owner_valid;
  // A grant ends either on a valid gap in SEND or when a completed byte
  // was the last of its message (or of the burst).
  assign release_now = ((state_reg == SEND) && !owner_valid) ||
                       ((state_reg == WAIT_DONE) && !tx_busy_i &&
                        (last_cap_reg || burst_hit));

`ifdef UART_TX_ARB_BURST_LIMIT_EN
  localparam int CntW = $clog2(MaxBurst + 1);
  logic [CntW-1:0] burst_cnt_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      burst_cnt_reg <= '0;
    end else if (grant_take) begin
      burst_cnt_reg <= '0;
    end else if (accept) begin
      burst_cnt_reg <= burst_cnt_reg + CntW'(1);
    end
  end

  assign burst_hit = (burst_cnt_reg == CntW'(MaxBurst));
`else
  // No burst limit: only last bytes and valid gaps end a grant. MaxBurst is
  // referenced so the parameter stays visible; the term is constant false.
  assign burst_hit = (MaxBurst < 0);
`endif

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (grant_take) begin
          state_next = SEND;
        end
      end
      SEND: begin
        state_next = owner_valid ? START : IDLE;
      end
      START: begin
        if (tx_busy_i) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy_i) begin
          state_next = (last_cap_reg || burst_hit) ? IDLE : SEND;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: ready is a combinational handshake to the owner only.
  always_comb begin
    req_ready_o = '0;
    if (accept) begin
      req_ready_o = grant_reg;
    end
  end

  // Datapath and grant bookkeeping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      armed_reg      <= 1'b0;
      grant_reg      <= '0;
      owner_reg      <= '0;
      last_owner_reg <= IdxW'(NumReq - 1);
      data_reg       <= '0;
      last_cap_reg   <= 1'b0;
      dv_reg         <= 1'b0;
    end else begin
      armed_reg <= 1'b1;
      dv_reg    <= accept;
      if (grant_take) begin
        grant_reg <= arb_grant;
        owner_reg <= arb_idx;
      end
      if (accept) begin
        data_reg     <= req_data_arr[owner_reg];
        last_cap_reg <= req_last_i[owner_reg];
      end
      if (release_now) begin
        grant_reg      <= '0;
        last_owner_reg <= owner_reg;
      end
    end
  end

  assign tx_dv_o   = dv_reg;
  assign tx_data_o = data_reg;
  assign grant_o   = grant_reg;

endmodule

// File: tb/tb_uart_tx_arb.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arb -- randomized self-checking bench for uart_tx_arb.
//
// Requesters are byte queues; a transmitter model answers tx_dv_o with a
// configurable busy window. The reference model drains copies of the queues
// using the arbitration rules directly (round-robin from last owner, whole
// message per grant, gap release, optional burst cap) and the transmitted
// (owner, byte) log is compared against it.
// ---------------------------------------------------------------------------
module tb_uart_tx_arb;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [NREQ-1:0]   req_valid_i = '0;
  logic [NREQ*DW-1:0] req_data_i = '0;
  logic [NREQ-1:0]   req_last_i = '0;
  logic [NREQ-1:0]   req_ready_o;
  logic              tx_dv_o;
  logic [DW-1:0]     tx_data_o;
  logic              tx_busy_i = 1'b0;
  logic [NREQ-1:0]   grant_o;

  always #5 clk_i = ~clk_i;

  uart_tx_arb #(
    .NumReq    (NREQ),
    .DataWidth (DW),
    .MaxBurst  (MAXB)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_dv_o     (tx_dv_o),
    .tx_data_o   (tx_data_o),
    .tx_busy_i   (tx_busy_i),
    .grant_o     (grant_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  // Requester side: bit DW of each entry is the last flag.
  logic [DW:0] rq [NREQ][$];
  logic [DW:0] mq [NREQ][$];
  bit          acc [NREQ];
  bit          stall [NREQ];
  bit          stall_after_pop [NREQ];

  // Logs and expectations
  int          log_owner [$];
  logic [DW-1:0] log_data [$];
  int          exp_owner [$];
  logic [DW-1:0] exp_data [$];
  int          model_last = NREQ - 1;

  // Transmitter model state
  int busy_delay = 0;
  int busy_len   = 4;
  bit d_act      = 0;
  int d_cnt      = 0;
  int b_cnt      = 0;
  int dv_total   = 0;
  int viol_rules = 0;
  int viol_data  = 0;
  logic [DW-1:0] cur_data = '0;

  function automatic int oh2idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int k = 0; k < NREQ; k++) if (v[k]) r = k;
    return r;
  endfunction

  task automatic push_byte(input int k, input logic [DW-1:0] d, input bit last, input bit to_model);
    rq[k].push_back({last, d});
    if (to_model) mq[k].push_back({last, d});
  endtask

  // Reference model: drain mq by the arbitration rules.
  task automatic model_drain();
    bit any;
    int k, cnt;
    logic [DW:0] b;
    forever begin
      any = 0;
      for (int i = 0; i < NREQ; i++) if (mq[i].size() > 0) any = 1;
      if (!any) break;
      k = model_last;
      do k = (k + 1) % NREQ; while (mq[k].size() == 0);
      cnt = 0;
      forever begin
        b = mq[k].pop_front();
        exp_owner.push_back(k);
        exp_data.push_back(b[DW-1:0]);
        cnt++;
        if (b[DW] || mq[k].size() == 0) break;
`ifdef UART_TX_ARB_BURST_LIMIT_EN
        if (cnt == MAXB) break;
`endif
      end
      model_last = k;
    end
  endtask

  // Requester driver: pop accepted bytes after the edge, present next head.
  initial forever begin
    @(posedge clk_i); #1;
    for (int k = 0; k < NREQ; k++) begin
      if (acc[k] && rq[k].size() > 0) begin
        void'(rq[k].pop_front());
        if (stall_after_pop[k]) begin
          stall[k] = 1;
          stall_after_pop[k] = 0;
        end
      end
      acc[k] = 0;
      req_valid_i[k] = (rq[k].size() > 0) && !stall[k];
      req_data_i[k*DW +: DW] = (rq[k].size() > 0) ? rq[k][0][DW-1:0] : '0;
      req_last_i[k] = (rq[k].size() > 0) ? rq[k][0][DW] : 1'b0;
    end
  end

  // Transmitter model and protocol monitor, on the falling edge.
  initial forever begin
    @(negedge clk_i);
    for (int k = 0; k < NREQ; k++) acc[k] = req_ready_o[k];
    if ((req_ready_o & ~grant_o) != 0) viol_rules++;
    if ($countones(req_ready_o) > 1) viol_rules++;
    if (tx_dv_o && req_ready_o != 0) viol_rules++;
    if (rst_i) begin
      tx_busy_i = 0;
      d_act = 0;
    end else begin
      if (tx_busy_i) begin
        if (b_cnt <= 1) tx_busy_i = 0;
        else b_cnt--;
      end
      if (tx_dv_o) begin
        dv_total++;
        if (grant_o == 0) viol_rules++;
        log_owner.push_back(oh2idx(grant_o));
        log_data.push_back(tx_data_o);
        cur_data = tx_data_o;
        d_act = 1;
        d_cnt = busy_delay;
      end
      if (d_act) begin
        if (d_cnt == 0) begin
          tx_busy_i = 1;
          b_cnt = busy_len;
          d_act = 0;
        end else d_cnt--;
      end
      if (tx_busy_i && tx_data_o != cur_data) viol_data++;
    end
  end

  task automatic wait_done(input int n, input string tag);
    int cyc = 0;
    while (cyc < 3000 && !(log_owner.size() >= n && grant_o == 0 && !tx_busy_i && !d_act)) begin
      @(negedge clk_i); #1;
      cyc++;
    end
    check_val({tag, "_count"}, log_owner.size(), n);
  endtask

  task automatic compare_logs(input string tag);
    for (int i = 0; i < exp_owner.size() && i < log_owner.size(); i++) begin
      check_val($sformatf("%s_owner%0d", tag, i), log_owner[i], exp_owner[i]);
      check_val($sformatf("%s_data%0d", tag, i), log_data[i], exp_data[i]);
    end
    log_owner.delete(); log_data.delete();
    exp_owner.delete(); exp_data.delete();
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < NREQ; k++) begin
      rq[k].delete(); mq[k].delete();
      stall[k] = 0; stall_after_pop[k] = 0; acc[k] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1;
    clear_reqs();
    repeat (3) @(negedge clk_i);
    rst_i = 0;
    model_last = NREQ - 1;
    log_owner.delete(); log_data.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int waited, dv_before, rdy_cnt, nmsg, len, total;
    logic [DW-1:0] d;

    // Reset state and single-byte transfer with reset-release latency.
    busy_delay = 0; busy_len = 10;
    repeat (3) @(negedge clk_i);
    check_val("rst_grant", grant_o, 0);
    check_val("rst_ready", req_ready_o, 0);
    check_val("rst_dv", tx_dv_o, 0);
    check_val("rst_data", tx_data_o, 0);
    push_byte(0, 8'h41, 1, 0);
    @(posedge clk_i); #2;
    @(negedge clk_i);
    rst_i = 0;
    @(posedge clk_i); #1;
    check_val("first_edge_grant", grant_o, 0);
    @(posedge clk_i); #1;
    check_val("second_edge_grant", grant_o, 4'b0001);
    check_val("send_ready", req_ready_o, 4'b0001);
    @(posedge clk_i); #1;
    check_val("accept_ready_low", req_ready_o, 0);
    check_val("dv_pulse", tx_dv_o, 1);
    check_val("dv_data", tx_data_o, 8'h41);
    @(posedge clk_i); #1;
    check_val("dv_single", tx_dv_o, 0);
    waited = 0;
    while (grant_o != 0 && waited < 100) begin
      @(posedge clk_i); #1;
      waited++;
    end
    check_val("release_after_busy", (grant_o == 0) && (waited >= 10), 1);
    check_val("busy_low_at_release", tx_busy_i, 0);
    exp_owner.push_back(0); exp_data.push_back(8'h41);
    model_last = 0;
    wait_done(1, "single");
    compare_logs("single");

    // Round-robin order across three rounds of single-byte messages.
    busy_len = 3;
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < NREQ; k++) push_byte(k, 8'($urandom), 1, 1);
    model_drain();
    wait_done(12, "rr");
    for (int i = 0; i < 12 && i < log_owner.size(); i++)
      check_val($sformatf("rr_order%0d", i), log_owner[i], i % NREQ);
    compare_logs("rr");

    // Multi-byte message is not preempted by a waiting requester.
    for (int i = 0; i < 3; i++) push_byte(1, 8'h10 + 8'(i), i == 2, 1);
    push_byte(2, 8'h20, 1, 1);
    model_drain();
    wait_done(4, "nopreempt");
    compare_logs("nopreempt");

    // Owner drops valid after its first byte: gap release, next requester.
    push_byte(1, 8'hA1, 0, 0);
    push_byte(1, 8'hA2, 1, 0);
    stall_after_pop[1] = 1;
    push_byte(2, 8'hC0, 1, 0);
    exp_owner.push_back(1); exp_data.push_back(8'hA1);
    exp_owner.push_back(2); exp_data.push_back(8'hC0);
    wait_done(2, "gap");
    compare_logs("gap");
    stall[1] = 0;
    exp_owner.push_back(1); exp_data.push_back(8'hA2);
    wait_done(1, "gap_resume");
    compare_logs("gap_resume");
    model_last = 1;

    // Transmitter slow to raise busy: exactly one pulse, no ready meanwhile.
    busy_delay = 20; busy_len = 2;
    push_byte(2, 8'h55, 0, 1);
    push_byte(2, 8'h66, 1, 1);
    model_drain();
    waited = 0;
    while (log_owner.size() == 0 && waited < 200) begin
      @(negedge clk_i); #1;
      waited++;
    end
    dv_before = dv_total;
    rdy_cnt = 0;
    repeat (18) begin
      @(negedge clk_i); #1;
      if (req_ready_o != 0) rdy_cnt++;
    end
    check_val("slow_busy_ready", rdy_cnt, 0);
    check_val("slow_busy_pulses", dv_total - dv_before, 0);
    check_val("slow_busy_grant", grant_o, 4'b0100);
    wait_done(2, "slow_busy");
    compare_logs("slow_busy");

    // Long stream with a waiting requester (burst cap applies when enabled).
    busy_delay = 1; busy_len = 2;
    do_reset();
    for (int i = 0; i < 6; i++) push_byte(0, 8'h30 + 8'(i), 0, 1);
    push_byte(3, 8'h99, 1, 1);
    model_drain();
    wait_done(7, "burst");
    compare_logs("burst");

    // Randomized traffic.
    for (int round = 0; round < 4; round++) begin
      busy_delay = $urandom_range(0, 3);
      busy_len = $urandom_range(1, 6);
      total = 0;
      for (int k = 0; k < NREQ; k++) begin
        nmsg = $urandom_range(0, 3);
        for (int m = 0; m < nmsg; m++) begin
          len = $urandom_range(1, 5);
          for (int b = 0; b < len; b++) begin
            d = 8'($urandom);
            push_byte(k, d, (b == len - 1) && ($urandom_range(0, 3) != 0), 1);
            total++;
          end
        end
      end
      model_drain();
      wait_done(total, $sformatf("rand%0d", round));
      compare_logs($sformatf("rand%0d", round));
    end

    // Reset in the middle of a message: message dropped, no later pulse.
    busy_delay = 0; busy_len = 8;
    push_byte(2, 8'h71, 0, 0);
    push_byte(2, 8'h72, 0, 0);
    push_byte(2, 8'h73, 1, 0);
    waited = 0;
    while (log_owner.size() == 0 && waited < 200) begin
      @(negedge clk_i); #1;
      waited++;
    end
    @(negedge clk_i);
    rst_i = 1;
    clear_reqs();
    repeat (2) @(negedge clk_i);
    rst_i = 0;
    dv_before = dv_total;
    repeat (12) @(negedge clk_i);
    check_val("midrst_pulses", dv_total - dv_before, 0);
    check_val("midrst_grant", grant_o, 0);

    check_val("ready_rules", viol_rules, 0);
    check_val("data_stable", viol_data, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
